mem_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single mmio/SRAM memory port (stb/ack/addr/dtw/dtr/rw)

---
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one mmio/SRAM port between
// NUM_REQ bus masters. One transaction per grant, completed by m_ack.
// Optional build macro: ARB_TIMEOUT_EN adds a BUSY watchdog that forces an
// error completion (req_dtr = 32'hDEAD_BEEF, bus_err pulse) after
// TIMEOUT_CYCLES cycles without an ack.
module mem_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_stb,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_dtw,
  input  logic [NUM_REQ-1:0]   req_rw,
  output logic [31:0]          req_dtr,
  output logic                 m_stb,
  input  logic                 m_ack,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_dtw,
  input  logic [31:0]          m_dtr,
  output logic                 m_rw,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 bus_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [NUM_REQ-1:0] grant_next;
  logic [IDX_W-1:0]   last, last_next;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W:0]     cand;
  logic               g_stb;
  logic               timeout_hit;

  // Round-robin search starting just after the last winner; walking the
  // offsets from farthest to nearest lets the nearest requester win.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (req_stb[cand[IDX_W-1:0]]) winner = cand[IDX_W-1:0];
    end
  end

  // Route the granted requester's address/data/direction to mmio; requester 0 in IDLE.
  always_comb begin
    sel    = (state == BUSY) ? last : '0;
    m_addr = '0;
    m_dtw  = '0;
    m_rw   = 1'b0;
    g_stb  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        m_addr = req_addr[32*i +: 32];
        m_dtw  = req_dtw[32*i +: 32];
        m_rw   = req_rw[i];
      end
      if (last == IDX_W'(i)) g_stb = req_stb[i];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog: held at zero outside BUSY, counts BUSY cycles that see no ack.
  always_ff @(posedge clk) begin
    if (reset)                tmo_cnt <= '0;
    else if (state == IDLE)   tmo_cnt <= '0;
    else if (!m_ack)          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state == BUSY) && g_stb && !m_ack &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and per-cycle bus outputs for the IDLE/BUSY handshake.
  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    m_stb      = 1'b0;
    req_ack    = '0;
    req_dtr    = m_dtr;
    bus_err    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_stb) begin
          state_next = BUSY;
          grant_next = NUM_REQ'(1) << winner;
          last_next  = winner;
        end
      end
      BUSY: begin
        m_stb = g_stb;
        if (g_stb && (m_ack || timeout_hit)) begin
          req_ack    = NUM_REQ'(1) << last;
          req_dtr    = timeout_hit ? 32'hDEAD_BEEF : m_dtr;
          bus_err    = timeout_hit;
          state_next = IDLE;
          grant_next = '0;
        end else if (!g_stb) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (NUM_REQ=2).
// Expected completions are queued when a request is driven and popped when
// the DUT pulses req_ack. Covers ARB_TIMEOUT_EN when that macro is defined.
module tb_mem_bus_arbiter;

  localparam int N = 2;

  typedef struct {
    int          idx;
    logic [31:0] dtr;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_stb = '0;
  logic [N-1:0]    req_ack;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_dtw = '0;
  logic [N-1:0]    req_rw = '0;
  logic [31:0]     req_dtr;
  logic            m_stb;
  logic            m_ack = 1'b0;
  logic [31:0]     m_addr;
  logic [31:0]     m_dtw;
  logic [31:0]     m_dtr = '0;
  logic            m_rw;
  logic [N-1:0]    grant;
  logic            bus_err;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  mem_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_stb(req_stb), .req_ack(req_ack), .req_addr(req_addr), .req_dtw(req_dtw),
    .req_rw(req_rw), .req_dtr(req_dtr),
    .m_stb(m_stb), .m_ack(m_ack), .m_addr(m_addr), .m_dtw(m_dtw), .m_dtr(m_dtr),
    .m_rw(m_rw), .grant(grant), .bus_err(bus_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    req_stb = 2'b01;
    tick();
    tick();
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
    n_compared++;
    if (m_stb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m_stb: got %b expected 0", m_stb); end
    n_compared++;
    if (req_ack !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_req_ack: got %b expected 00", req_ack); end
    n_compared++;
    if (bus_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end
    tick();
    reset   = 1'b0;
    req_stb = '0;
    tick();
  endtask

  task automatic test_single_read();
    exp_t e;
    tick();
    req_stb        = 2'b01;
    req_addr[31:0] = 32'h100;
    req_rw[0]      = 1'b0;
    m_ack          = 1'b1;
    m_dtr          = 32'h1234;
    exp_q.push_back('{0, 32'h1234});
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL read_pre_m_stb: got %b expected 0", m_stb); end
    tick();
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b1) begin n_mismatched++; $display("[TB] FAIL read_m_stb: got %b expected 1", m_stb); end
    n_compared++;
    if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL read_grant: got %b expected 01", grant); end
    n_compared++;
    if (m_addr !== 32'h100 || m_rw !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL read_addr_rw: got %h/%b expected 00000100/0", m_addr, m_rw);
    end
    n_compared++;
    if (req_ack === 2'b00 || exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL read_ack: got %b expected 01", req_ack);
    end else begin
      e = exp_q.pop_front();
      if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
        n_mismatched++; $display("[TB] FAIL read_ack: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
      end
    end
    tick();
    req_stb = '0;
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b00 || m_stb !== 1'b0 || req_ack !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL read_release: got %b/%b/%b expected 00/0/00", grant, m_stb, req_ack);
    end
  endtask

  task automatic test_write_wait();
    exp_t e;
    tick();
    req_stb         = 2'b10;
    req_addr[63:32] = 32'hFF04;
    req_dtw[63:32]  = 32'h5;
    req_rw[1]       = 1'b1;
    m_ack           = 1'b0;
    m_dtr           = 32'hA5A5_0000;
    exp_q.push_back('{1, 32'hA5A5_0000});
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write_pre_m_stb: got %b expected 0", m_stb); end
    tick();
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b1 || grant !== 2'b10 || req_ack !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL write_wait_cycle: got %b/%b/%b expected 1/10/00", m_stb, grant, req_ack);
    end
    n_compared++;
    if (m_dtw !== 32'h5 || m_addr !== 32'hFF04 || m_rw !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL write_bus_1: got %h/%h/%b expected 00000005/0000ff04/1", m_dtw, m_addr, m_rw);
    end
    tick();
    m_ack = 1'b1;
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b1 || m_dtw !== 32'h5) begin
      n_mismatched++; $display("[TB] FAIL write_bus_2: got %b/%h expected 1/00000005", m_stb, m_dtw);
    end
    n_compared++;
    if (req_ack === 2'b00 || exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL write_ack: got %b expected 10", req_ack);
    end else begin
      e = exp_q.pop_front();
      if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
        n_mismatched++; $display("[TB] FAIL write_ack: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
      end
    end
    tick();
    req_stb = '0;
    m_ack   = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    int           exp_order[4] = '{0, 1, 0, 1};
    int           acks = 0;
    int           grants = 0;
    int           cyc = 0;
    logic [N-1:0] prev_grant = '0;
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back('{exp_order[k], 32'hC0DE_0000 + k});
    tick();
    req_stb = 2'b11;
    m_ack   = 1'b1;
    m_dtr   = 32'hC0DE_0000;
    while (acks < 4 && cyc < 30) begin
      @(negedge clk);
      if (grant !== 2'b00) begin
        n_compared++;
        if (grants >= 4 || grant !== (2'b01 << exp_order[grants])) begin
          n_mismatched++; $display("[TB] FAIL rr_order: got %b at grant %0d", grant, grants);
        end
        n_compared++;
        if (prev_grant !== 2'b00) begin
          n_mismatched++; $display("[TB] FAIL rr_turnaround: got previous grant %b expected 00", prev_grant);
        end
        grants++;
      end
      if (req_ack !== 2'b00) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++; $display("[TB] FAIL rr_ack: got %b expected none", req_ack);
        end else begin
          e = exp_q.pop_front();
          if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
            n_mismatched++; $display("[TB] FAIL rr_ack: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
          end
        end
        acks++;
      end
      prev_grant = grant;
      tick();
      m_dtr = 32'hC0DE_0000 + acks;
      cyc++;
    end
    req_stb = '0;
    m_ack   = 1'b0;
    n_compared++;
    if (acks != 4) begin n_mismatched++; $display("[TB] FAIL rr_count: got %0d acks expected 4", acks); end
    tick();
  endtask

  task automatic test_abort();
    exp_t e;
    do_reset();
    tick();
    req_stb = 2'b11;
    m_ack   = 1'b0;
    tick();
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b01 || req_ack !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL abort_grant0: got %b/%b expected 01/00", grant, req_ack);
    end
    tick();
    req_stb = 2'b10;
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b0 || req_ack !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL abort_drop: got %b/%b expected 0/00", m_stb, req_ack);
    end
    tick();
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b00 || req_ack !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL abort_idle: got %b/%b expected 00/00", grant, req_ack);
    end
    tick();
    m_ack = 1'b1;
    m_dtr = 32'h0BAD_0001;
    exp_q.push_back('{1, 32'h0BAD_0001});
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b10) begin n_mismatched++; $display("[TB] FAIL abort_grant1: got %b expected 10", grant); end
    n_compared++;
    if (req_ack === 2'b00 || exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL abort_ack1: got %b expected 10", req_ack);
    end else begin
      e = exp_q.pop_front();
      if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
        n_mismatched++; $display("[TB] FAIL abort_ack1: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
      end
    end
    tick();
    req_stb = '0;
    m_ack   = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    tick();
    req_stb = 2'b01;
    m_ack   = 1'b0;
    tick();
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b01 || m_stb !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL rstmid_busy: got %b/%b expected 01/1", grant, m_stb);
    end
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    req_stb = 2'b11;
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b00 || m_stb !== 1'b0 || req_ack !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL rstmid_idle: got %b/%b/%b expected 00/0/00", grant, m_stb, req_ack);
    end
    tick();
    m_ack = 1'b1;
    m_dtr = 32'h5A5A_5A5A;
    exp_q.push_back('{0, 32'h5A5A_5A5A});
    @(negedge clk);
    n_compared++;
    if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rstmid_rearb: got %b expected 01", grant); end
    n_compared++;
    if (req_ack === 2'b00 || exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL rstmid_ack: got %b expected 01", req_ack);
    end else begin
      e = exp_q.pop_front();
      if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
        n_mismatched++; $display("[TB] FAIL rstmid_ack: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
      end
    end
    tick();
    req_stb = '0;
    m_ack   = 1'b0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   busy = 0;
    bit   seen = 0;
    tick();
    req_stb = 2'b01;
    m_ack   = 1'b0;
    m_dtr   = 32'h1111_2222;
    exp_q.push_back('{0, 32'hDEAD_BEEF});
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      @(negedge clk);
      if (m_stb === 1'b1) busy++;
      n_compared++;
      if (req_ack !== 2'b00) begin
        seen = 1;
        // Forced completion lands in the TIMEOUT_CYCLES-th BUSY cycle.
        if (busy != 8 || bus_err !== 1'b1 || exp_q.size() == 0) begin
          n_mismatched++; $display("[TB] FAIL tmo_pulse: got busy=%0d bus_err=%b expected 8/1", busy, bus_err);
        end else begin
          e = exp_q.pop_front();
          if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
            n_mismatched++; $display("[TB] FAIL tmo_ack: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
          end
        end
      end else if (bus_err !== 1'b0) begin
        n_mismatched++; $display("[TB] FAIL tmo_early_err: got %b expected 0 at busy=%0d", bus_err, busy);
      end
      tick();
    end
    req_stb = '0;
    n_compared++;
    if (!seen) begin n_mismatched++; $display("[TB] FAIL tmo_missing: got no ack expected ack after 8 cycles"); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    exp_t e;
    tick();
    req_stb = 2'b01;
    m_ack   = 1'b0;
    m_dtr   = 32'h7777_0001;
    exp_q.push_back('{0, 32'h7777_0001});
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      n_compared++;
      if (bus_err !== 1'b0 || req_ack !== 2'b00) begin
        n_mismatched++; $display("[TB] FAIL wait_quiet: got %b/%b expected 0/00 at cycle %0d", bus_err, req_ack, cyc);
      end
      tick();
    end
    @(negedge clk);
    n_compared++;
    if (m_stb !== 1'b1 || grant !== 2'b01) begin
      n_mismatched++; $display("[TB] FAIL wait_still_busy: got %b/%b expected 1/01", m_stb, grant);
    end
    tick();
    m_ack = 1'b1;
    @(negedge clk);
    n_compared++;
    if (req_ack === 2'b00 || exp_q.size() == 0) begin
      n_mismatched++; $display("[TB] FAIL wait_ack: got %b expected 01", req_ack);
    end else begin
      e = exp_q.pop_front();
      if (req_ack !== (2'b01 << e.idx) || req_dtr !== e.dtr) begin
        n_mismatched++; $display("[TB] FAIL wait_ack: got %b/%h expected %0d/%h", req_ack, req_dtr, e.idx, e.dtr);
      end
    end
    tick();
    req_stb = '0;
    m_ack   = 1'b0;
    tick();
  endtask
`endif

  // Scenario sequence, final scoreboard drain check and summary.
  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
